// File: rtl/audio_pkg.sv
// Shared types and default widths for the audio FIFO read path.
package audio_pkg;

   localparam int AUDIO_DATA_W = 32;
   localparam int AUDIO_DIV_W  = 32;
   localparam int AUDIO_UF_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      FLUSH = 2'd3
   } fifo_rd_state_t;

endpackage

// File: rtl/rate_divider.sv
// Sample-rate divider: counts while enabled, holds while disabled, clears on request.
module rate_divider
   import audio_pkg::*;
#(
   parameter int DIV_W = AUDIO_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] limit_s;
   logic             at_limit_s;

   // Wrap on >= so a lowered divisor never lets the counter run past the wrap point.
   always_comb begin
      limit_s    = (div == '0) ? '0 : (div - DIV_ONE);
      at_limit_s = (cnt_q >= limit_s);
      tick       = en & at_limit_s;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_limit_s ? '0 : (cnt_q + DIV_ONE);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/audio_fifo_reader.sv
// Read side of the audio sample FIFO: paced pops, held sample with strobe,
// pause/stop handling and saturating underflow count.
module audio_fifo_reader
   import audio_pkg::*;
#(
   parameter int DATA_W = AUDIO_DATA_W,
   parameter int DIV_W  = AUDIO_DIV_W,
   parameter int UF_W   = AUDIO_UF_W
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [DIV_W-1:0]  div_freq,
   input  logic              pause,
   input  logic              stop,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              underflow,
   output logic [UF_W-1:0]   underflow_cnt,
   output logic              playing
);

   localparam logic [UF_W-1:0] UF_ONE = {{(UF_W-1){1'b0}}, 1'b1};

   fifo_rd_state_t    state_q, state_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] sample_out_q, sample_out_d;
   logic              sample_valid_q, sample_valid_d;
   logic              underflow_q, underflow_d;
   logic [UF_W-1:0]   uf_cnt_q, uf_cnt_d;
   logic              playing_q, playing_d;

   logic tick_s;
   logic run_s;
   logic flush_s;
   logic run_read_s;
   logic flush_read_s;
   logic uf_event_s;
   logic enter_flush_s;

   assign run_s   = (state_q == RUN);
   assign flush_s = (state_q == FLUSH);

   rate_divider #(
      .DIV_W (DIV_W)
   ) u_rate_divider (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .en    (run_s),
      .clr   ((state_q == IDLE) | flush_s),
      .div   (div_freq),
      .tick  (tick_s)
   );

   // A pause seen this cycle already blocks the pop, even before PAUSE is entered.
   assign run_read_s   = run_s & tick_s & ~fifo_empty & ~pause;
   assign flush_read_s = flush_s & ~fifo_empty;
   assign uf_event_s   = run_s & tick_s & fifo_empty;
   assign fifo_rdreq   = run_read_s | flush_read_s;

   // Playback state machine; stop dominates pause from every state.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE:    state_d = pause ? PAUSE : RUN;
            RUN:     state_d = pause ? PAUSE : RUN;
            PAUSE:   state_d = pause ? PAUSE : RUN;
            FLUSH:   state_d = fifo_empty ? IDLE : FLUSH;
            default: state_d = IDLE;
         endcase
      end
   end

   assign enter_flush_s = (state_d == FLUSH) & (state_q != FLUSH);

   // Output datapath; entering FLUSH discards any word still in flight.
   always_comb begin
      pend_d         = run_read_s & ~enter_flush_s;
      sample_valid_d = pend_q & ~enter_flush_s;
      underflow_d    = uf_event_s & ~enter_flush_s;
      playing_d      = (state_d == RUN);

      if (enter_flush_s) begin
         sample_out_d = '0;
      end else if (pend_q) begin
         sample_out_d = fifo_q;
      end else begin
         sample_out_d = sample_out_q;
      end

      if (enter_flush_s) begin
         uf_cnt_d = '0;
      end else if (uf_event_s && !(&uf_cnt_q)) begin
         uf_cnt_d = uf_cnt_q + UF_ONE;
      end else begin
         uf_cnt_d = uf_cnt_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q        <= IDLE;
         pend_q         <= 1'b0;
         sample_out_q   <= '0;
         sample_valid_q <= 1'b0;
         underflow_q    <= 1'b0;
         uf_cnt_q       <= '0;
         playing_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         pend_q         <= pend_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         underflow_q    <= underflow_d;
         uf_cnt_q       <= uf_cnt_d;
         playing_q      <= playing_d;
      end
   end

   assign sample_out    = sample_out_q;
   assign sample_valid  = sample_valid_q;
   assign underflow     = underflow_q;
   assign underflow_cnt = uf_cnt_q;
   assign playing       = playing_q;

endmodule

// File: tb/tb_audio_fifo_reader.sv
// Self-checking bench: emulated FIFO, behavioural playback model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_audio_fifo_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] div_freq;
   logic        pause;
   logic        stop;
   logic        fifo_empty;
   logic [31:0] fifo_q = 32'h0;
   logic        fifo_rdreq;
   logic [31:0] sample_out;
   logic        sample_valid;
   logic        underflow;
   logic [15:0] underflow_cnt;
   logic        playing;

   always #5 clk = ~clk;

   audio_fifo_reader dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .div_freq      (div_freq),
      .pause         (pause),
      .stop          (stop),
      .fifo_empty    (fifo_empty),
      .fifo_q        (fifo_q),
      .fifo_rdreq    (fifo_rdreq),
      .sample_out    (sample_out),
      .sample_valid  (sample_valid),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt),
      .playing       (playing)
   );

   // FIFO emulation (normal mode: data one cycle after the request)
   logic [31:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rdreq === 1'b1 && wr_ptr != rd_ptr) begin
         fifo_q <= mem[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // model: mode 0 idle, 1 run, 2 pause, 3 flush
   int          m_mode = 0;
   int          m_phase = 0;
   logic [31:0] m_out = 32'h0;
   bit          m_valid = 1'b0;
   bit          m_uf = 1'b0;
   int          m_ucnt = 0;
   bit          m_play = 1'b0;
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_word = 32'h0;
   int          m_rd = 0;

   int          rd_cycs[$];
   logic [31:0] seen[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr % 1024] = w;
      wr_ptr++;
   endtask

   // Compare DUT against the model for the current cycle, then advance the model.
   task automatic model_step();
      int          period;
      bit          tick, empty, run_rd, rd, ent, ufe;
      logic [31:0] word;

      chk("sample_out", sample_out, m_out);
      chk("sample_valid", {31'b0, sample_valid}, {31'b0, m_valid});
      chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
      chk("underflow_cnt", {16'b0, underflow_cnt}, m_ucnt);
      chk("playing", {31'b0, playing}, {31'b0, m_play});

      period = (div_freq < 32'd2) ? 1 : int'(div_freq);
      empty  = (wr_ptr == m_rd);
      tick   = (m_mode == 1) && (m_phase + 1 >= period);
      run_rd = tick && !empty && !pause;
      rd     = run_rd || (m_mode == 3 && !empty);
      chk("fifo_rdreq", {31'b0, fifo_rdreq}, {31'b0, rd});

      if (fifo_rdreq === 1'b1) rd_cycs.push_back(cyc);
      if (sample_valid === 1'b1) seen.push_back(sample_out);

      word = mem[m_rd % 1024];
      if (rd) m_rd++;
      ent = stop && (m_mode != 3);
      ufe = tick && empty;

      if (!rst_n) begin
         m_mode = 0; m_phase = 0; m_out = 32'h0; m_valid = 1'b0; m_uf = 1'b0;
         m_ucnt = 0; m_play = 1'b0; m_pend = 1'b0;
      end else begin
         m_valid     = m_pend && !ent;
         m_out       = ent ? 32'h0 : (m_pend ? m_pend_word : m_out);
         m_pend      = run_rd && !ent;
         m_pend_word = word;
         m_uf        = ufe && !ent;
         m_ucnt      = ent ? 0 : ((ufe && m_ucnt < 65535) ? m_ucnt + 1 : m_ucnt);
         m_phase     = (m_mode == 1) ? (tick ? 0 : m_phase + 1) : ((m_mode == 2) ? m_phase : 0);
         if (stop)             m_mode = 3;
         else if (m_mode == 3) m_mode = empty ? 0 : 3;
         else                  m_mode = pause ? 2 : 1;
         m_play = (m_mode == 1);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      bit found;

      rst_n = 1'b0; div_freq = 32'd4; pause = 1'b0; stop = 1'b0;
      push(32'h11112222); push(32'h33334444); push(32'h55556666);
      @(posedge clk);
      #1;
      cycle(); cycle();

      // div 4: three reads spaced by 4, then underflow
      rst_n = 1'b1;
      rd_cycs.delete(); seen.delete();
      repeat (24) cycle();
      chk("t1_reads", rd_cycs.size(), 32'd3);
      if (rd_cycs.size() == 3) begin
         chk("t1_gap0", rd_cycs[1] - rd_cycs[0], 32'd4);
         chk("t1_gap1", rd_cycs[2] - rd_cycs[1], 32'd4);
      end
      chk("t1_seen", seen.size(), 32'd3);
      if (seen.size() == 3) begin
         chk("t1_w0", seen[0], 32'h11112222);
         chk("t1_w1", seen[1], 32'h33334444);
         chk("t1_w2", seen[2], 32'h55556666);
      end

      // div 0: five back-to-back reads then per-cycle underflow
      stop = 1'b1; repeat (3) cycle();
      stop = 1'b0; pause = 1'b1; repeat (3) cycle();
      for (int i = 1; i <= 5; i++) push(32'hA0000000 + i);
      div_freq = 32'd0; rd_cycs.delete(); seen.delete();
      pause = 1'b0;
      repeat (14) cycle();
      chk("t2_reads", rd_cycs.size(), 32'd5);
      if (rd_cycs.size() == 5) chk("t2_span", rd_cycs[4] - rd_cycs[0], 32'd4);
      chk("t2_seen", seen.size(), 32'd5);
      chk("t2_hold", sample_out, 32'hA0000005);
      chk("t2_ucnt", {16'b0, underflow_cnt}, 32'd8);

      // div 10: pause at counter 6 for 20 cycles
      pause = 1'b1; cycle();
      for (int i = 1; i <= 4; i++) push(32'hB0000000 + i);
      div_freq = 32'd10; pause = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (m_mode == 1 && m_phase == 6) found = 1'b1;
      end
      chk("t3_found", {31'b0, found}, 32'd1);
      pause = 1'b1; rd_cycs.delete();
      repeat (20) cycle();
      chk("t3_noread", rd_cycs.size(), 32'd0);
      pause = 1'b0; t0 = cyc;
      repeat (8) cycle();
      chk("t3_first", rd_cycs.size(), 32'd1);
      if (rd_cycs.size() > 0) chk("t3_delay", rd_cycs[0] - t0, 32'd3);
      repeat (40) cycle();
      chk("t3_drained", {31'b0, fifo_empty}, 32'd1);

      // stop with 8 words queued, pause also high
      pause = 1'b1; cycle();
      for (int i = 1; i <= 8; i++) push(32'hC0000000 + i);
      cycle(); cycle();
      rd_cycs.delete(); seen.delete();
      stop = 1'b1;
      cycle();
      chk("t4_zero", sample_out, 32'h0);
      repeat (12) cycle();
      chk("t4_reads", rd_cycs.size(), 32'd8);
      if (rd_cycs.size() == 8) chk("t4_span", rd_cycs[7] - rd_cycs[0], 32'd7);
      chk("t4_novalid", seen.size(), 32'd0);
      chk("t4_playing", {31'b0, playing}, 32'd0);
      stop = 1'b0; pause = 1'b0;
      repeat (3) cycle();

      // saturate the underflow counter
      div_freq = 32'd0;
      repeat (65540) cycle();
      chk("t5_sat", {16'b0, underflow_cnt}, 32'h0000FFFF);
      chk("t5_pulse", {31'b0, underflow}, 32'd1);
      stop = 1'b1; cycle(); cycle();
      chk("t5_clear", {16'b0, underflow_cnt}, 32'd0);

      // reset between request and latch
      stop = 1'b0; pause = 1'b1; repeat (3) cycle();
      push(32'hD00D0001);
      div_freq = 32'd2; rd_cycs.delete(); seen.delete();
      pause = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (rd_cycs.size() > 0) found = 1'b1;
      end
      chk("t6_read", {31'b0, found}, 32'd1);
      rst_n = 1'b0; cycle();
      rst_n = 1'b1;
      chk("t6_out", sample_out, 32'h0);
      chk("t6_valid", {31'b0, sample_valid}, 32'd0);
      chk("t6_idle", {31'b0, playing}, 32'd0);
      repeat (5) cycle();
      chk("t6_novalid", seen.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
